// File: rtl/uart_rx_word_packer_if.sv
// Byte-in / word-out bundle for uart_rx_word_packer.
// slave: the packer itself. master: whoever feeds bytes and drains words.
interface uart_rx_word_packer_if #(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned DEPTH          = 4
);
  localparam int unsigned W      = 8 * BYTES_PER_WORD;
  localparam int unsigned LevelW = $clog2(DEPTH + 1);
  localparam int unsigned CountW = $clog2(BYTES_PER_WORD + 1);

  // Byte side
  logic              rx_done;
  logic [7:0]        rx_byte;
  logic              flush;
  // Word side
  logic [W-1:0]      word_data;
  logic              word_valid;
  logic              word_ready;
  // Status
  logic [LevelW-1:0] fifo_level;
  logic [CountW-1:0] byte_count;
  logic              overrun;
  logic              timeout;
  logic [7:0]        drop_count;

  modport master (
    output rx_done, rx_byte, flush, word_ready,
    input  word_data, word_valid, fifo_level, byte_count, overrun, timeout, drop_count
  );

  modport slave (
    input  rx_done, rx_byte, flush, word_ready,
    output word_data, word_valid, fifo_level, byte_count, overrun, timeout, drop_count
  );
endinterface

// File: rtl/uart_rx_word_packer.sv
// Packs UART bytes into BYTES_PER_WORD-byte words and queues them in a small
// first-word-fall-through FIFO drained over valid/ready. Stalled partial words
// are dropped after TIMEOUT_CYCLES idle clocks; flush drops them on demand.
module uart_rx_word_packer #(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter bit          MSB_FIRST      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned DEPTH          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_rx_word_packer_if.slave  bus
);

  localparam int unsigned W         = 8 * BYTES_PER_WORD;
  localparam int unsigned CountW    = $clog2(BYTES_PER_WORD + 1);
  localparam int unsigned LevelW    = $clog2(DEPTH + 1);
  localparam int unsigned PtrW      = $clog2(DEPTH);
  localparam bit          TimeoutEn = (TIMEOUT_CYCLES > 0);
  localparam int unsigned TimerW    = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CountW-1:0] LastSlot  = CountW'(BYTES_PER_WORD - 1);
  localparam logic [LevelW-1:0] LevelFull = LevelW'(DEPTH);
  // Expiry is decided in the cycle whose edge would bring the timer to TIMEOUT_CYCLES.
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutEn ? TIMEOUT_CYCLES - 1 : 0);

  // Accumulator state
  logic [W-1:0]      acc_q, acc_d;
  logic [CountW-1:0] count_q, count_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              timeout_q, timeout_d;
  logic [CountW-1:0] slot;
  logic              push_req;

  // FIFO state
  logic [W-1:0]      mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        drop_q, drop_d;
  logic              full;
  logic              pop;
  logic              push;

  // Byte accept, word completion, idle timer and flush handling.
  always_comb begin
    acc_d     = acc_q;
    count_d   = count_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    push_req  = 1'b0;
    slot      = MSB_FIRST ? (LastSlot - count_q) : count_q;

    if (bus.flush) begin
      // Flush beats a coincident byte, completion and timeout.
      count_d = '0;
      timer_d = '0;
    end else if (bus.rx_done) begin
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
        if (slot == CountW'(i)) begin
          acc_d[8*i +: 8] = bus.rx_byte;
        end
      end
      timer_d = '0;
      if (count_q == LastSlot) begin
        push_req = 1'b1;
        count_d  = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (count_q == '0) begin
      timer_d = '0;
    end else if (TimeoutEn) begin
      if (timer_q == TimerLast) begin
        count_d   = '0;
        timer_d   = '0;
        timeout_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // FIFO push/pop bookkeeping; a pop in the same cycle frees room for a push when full.
  always_comb begin
    pop       = (level_q != '0) && bus.word_ready;
    full      = (level_q == LevelFull);
    push      = push_req && (!full || pop);
    overrun_d = push_req && full && !pop;
    drop_d    = (overrun_d && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      acc_q     <= acc_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

  // Word storage; contents are only observed through valid entries, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= acc_d;
    end
  end

  // Outputs; word_data is forced to zero while empty so reset shows all-zero outputs.
  assign bus.word_data  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.word_valid = (level_q != '0);
  assign bus.fifo_level = level_q;
  assign bus.byte_count = count_q;
  assign bus.overrun    = overrun_q;
  assign bus.timeout    = timeout_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Bench for uart_rx_word_packer: three configurations, directed byte streams,
// a per-instance scoreboard of expected words checked by negedge monitors.
module tb_uart_rx_word_packer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_word_packer_if #(.BYTES_PER_WORD(4), .DEPTH(4)) bus0 ();
  uart_rx_word_packer_if #(.BYTES_PER_WORD(4), .DEPTH(4)) bus1 ();
  uart_rx_word_packer_if #(.BYTES_PER_WORD(2), .DEPTH(4)) bus2 ();

  // LSB-first, 16-cycle timeout: main instance
  uart_rx_word_packer #(
    .BYTES_PER_WORD(4), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(16), .DEPTH(4)
  ) u_dut0 (.clk(clk), .reset(rst_n), .bus(bus0));

  // MSB-first, timeout disabled
  uart_rx_word_packer #(
    .BYTES_PER_WORD(4), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(0), .DEPTH(4)
  ) u_dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

  // 2-byte words, LSB-first
  uart_rx_word_packer #(
    .BYTES_PER_WORD(2), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(0), .DEPTH(4)
  ) u_dut2 (.clk(clk), .reset(rst_n), .bus(bus2));

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic no_word(input string name, input logic [31:0] act);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got word %h, required none queued", name, act);
  endtask

  // Monitors: a word is consumed when valid & ready are seen before the next edge.
  always @(negedge clk) begin
    if (rst_n && bus0.word_valid && bus0.word_ready) begin
      if (q0.size() == 0) no_word("u0_unexpected_word", bus0.word_data);
      else check("u0_word", bus0.word_data, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus1.word_valid && bus1.word_ready) begin
      if (q1.size() == 0) no_word("u1_unexpected_word", bus1.word_data);
      else check("u1_word", bus1.word_data, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus2.word_valid && bus2.word_ready) begin
      if (q2.size() == 0) no_word("u2_unexpected_word", 32'(bus2.word_data));
      else check("u2_word", 32'(bus2.word_data), q2.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] b);
    bus0.rx_byte = b;
    bus0.rx_done = 1'b1;
    tick();
    bus0.rx_done = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    bus1.rx_byte = b;
    bus1.rx_done = 1'b1;
    tick();
    bus1.rx_done = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    bus2.rx_byte = b;
    bus2.rx_done = 1'b1;
    tick();
    bus2.rx_done = 1'b0;
  endtask

  // Word n is bytes n, n+0x10, n+0x20, n+0x30 sent LSB first.
  function automatic logic [31:0] wordn(input int n);
    return {8'(n + 48), 8'(n + 32), 8'(n + 16), 8'(n)};
  endfunction

  task automatic send_word0(input int n, input bit expect_push);
    if (expect_push) q0.push_back(wordn(n));
    send0(8'(n));
    send0(8'(n + 16));
    send0(8'(n + 32));
    send0(8'(n + 48));
  endtask

  initial begin
    bus0.rx_done = 1'b0; bus0.rx_byte = '0; bus0.flush = 1'b0; bus0.word_ready = 1'b0;
    bus1.rx_done = 1'b0; bus1.rx_byte = '0; bus1.flush = 1'b0; bus1.word_ready = 1'b0;
    bus2.rx_done = 1'b0; bus2.rx_byte = '0; bus2.flush = 1'b0; bus2.word_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_valid", 32'(bus0.word_valid), 32'd0);
    check("rst_level", 32'(bus0.fifo_level), 32'd0);
    check("rst_count", 32'(bus0.byte_count), 32'd0);
    check("rst_data", bus0.word_data, 32'd0);
    check("rst_drop", 32'(bus0.drop_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: LSB-first float 1.0
    bus0.word_ready = 1'b1;
    q0.push_back(32'h3F80_0000);
    send0(8'h00); send0(8'h00); send0(8'h80);
    check("t1_count3", 32'(bus0.byte_count), 32'd3);
    check("t1_valid_early", 32'(bus0.word_valid), 32'd0);
    send0(8'h3F);
    check("t1_count0", 32'(bus0.byte_count), 32'd0);
    check("t1_valid", 32'(bus0.word_valid), 32'd1);
    check("t1_level", 32'(bus0.fifo_level), 32'd1);
    tick();
    check("t1_drained", 32'(bus0.word_valid), 32'd0);

    // 2: MSB-first and 2-byte words
    bus1.word_ready = 1'b1;
    bus2.word_ready = 1'b1;
    q1.push_back(32'h3F80_0000);
    send1(8'h3F); send1(8'h80); send1(8'h00); send1(8'h00);
    check("t2_u1_valid", 32'(bus1.word_valid), 32'd1);
    q2.push_back(32'h0000_1234);
    q2.push_back(32'h0000_CDAB);
    send2(8'h34); send2(8'h12); send2(8'hAB); send2(8'hCD);
    tick(); tick();

    // 3: overflow with consumer stalled, then drain in order
    bus0.word_ready = 1'b0;
    for (int n = 1; n <= 4; n++) send_word0(n, 1'b1);
    check("t3_level_full", 32'(bus0.fifo_level), 32'd4);
    check("t3_no_overrun_yet", 32'(bus0.overrun), 32'd0);
    send_word0(5, 1'b0);
    check("t3_overrun", 32'(bus0.overrun), 32'd1);
    check("t3_drop1", 32'(bus0.drop_count), 32'd1);
    check("t3_level_kept", 32'(bus0.fifo_level), 32'd4);
    tick();
    check("t3_overrun_pulse", 32'(bus0.overrun), 32'd0);
    bus0.word_ready = 1'b1;
    tick();
    check("t3_level3", 32'(bus0.fifo_level), 32'd3);
    tick(); tick(); tick();
    check("t3_level0", 32'(bus0.fifo_level), 32'd0);
    check("t3_empty", 32'(bus0.word_valid), 32'd0);

    // 3b: pop in the same cycle as completion while full
    bus0.word_ready = 1'b0;
    for (int n = 6; n <= 9; n++) send_word0(n, 1'b1);
    check("t3b_level_full", 32'(bus0.fifo_level), 32'd4);
    q0.push_back(wordn(10));
    send0(8'(10)); send0(8'(26)); send0(8'(42));
    bus0.word_ready = 1'b1;
    send0(8'(58));
    check("t3b_no_overrun", 32'(bus0.overrun), 32'd0);
    check("t3b_level_full2", 32'(bus0.fifo_level), 32'd4);
    check("t3b_drop_same", 32'(bus0.drop_count), 32'd1);
    repeat (4) tick();
    check("t3b_level0", 32'(bus0.fifo_level), 32'd0);

    // 4: timeout after 16 idle clocks
    send0(8'hAA); send0(8'hBB);
    repeat (15) tick();
    check("t4_count_held", 32'(bus0.byte_count), 32'd2);
    check("t4_no_timeout_yet", 32'(bus0.timeout), 32'd0);
    tick();
    check("t4_timeout", 32'(bus0.timeout), 32'd1);
    check("t4_count0", 32'(bus0.byte_count), 32'd0);
    tick();
    check("t4_timeout_pulse", 32'(bus0.timeout), 32'd0);
    q0.push_back(32'h4433_2211);
    send0(8'h11); send0(8'h22); send0(8'h33); send0(8'h44);
    tick(); tick();
    // Byte arriving in the expiry cycle wins
    send0(8'h55); send0(8'h66);
    repeat (15) tick();
    send0(8'h77);
    check("t4b_count3", 32'(bus0.byte_count), 32'd3);
    check("t4b_no_timeout", 32'(bus0.timeout), 32'd0);
    q0.push_back(32'h8877_6655);
    send0(8'h88);
    tick(); tick();

    // 5: flush
    send0(8'h01); send0(8'h02); send0(8'h03);
    bus0.flush = 1'b1;
    tick();
    bus0.flush = 1'b0;
    check("t5_count0", 32'(bus0.byte_count), 32'd0);
    check("t5_no_word", 32'(bus0.word_valid), 32'd0);
    send0(8'hE1); send0(8'hE2); send0(8'hE3);
    bus0.flush = 1'b1;
    send0(8'hE4);
    bus0.flush = 1'b0;
    check("t5b_count0", 32'(bus0.byte_count), 32'd0);
    check("t5b_no_word", 32'(bus0.word_valid), 32'd0);
    q0.push_back(32'hD4D3_D2D1);
    send0(8'hD1); send0(8'hD2); send0(8'hD3); send0(8'hD4);
    tick(); tick();

    // 6: asynchronous reset mid-word with words queued (those words are discarded)
    bus0.word_ready = 1'b0;
    send_word0(11, 1'b0);
    send_word0(12, 1'b0);
    send0(8'hF1); send0(8'hF2);
    check("t6_level2", 32'(bus0.fifo_level), 32'd2);
    check("t6_count2", 32'(bus0.byte_count), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus0.word_valid), 32'd0);
    check("t6_rst_level", 32'(bus0.fifo_level), 32'd0);
    check("t6_rst_count", 32'(bus0.byte_count), 32'd0);
    check("t6_rst_data", bus0.word_data, 32'd0);
    check("t6_rst_drop", 32'(bus0.drop_count), 32'd0);
    check("t6_rst_flags", {30'd0, bus0.overrun, bus0.timeout}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus0.word_ready = 1'b1;
    q0.push_back(32'h9988_7766);
    send0(8'h66); send0(8'h77); send0(8'h88); send0(8'h99);
    check("t6_one_word", 32'(bus0.fifo_level), 32'd1);
    repeat (3) tick();
    check("t6_level0", 32'(bus0.fifo_level), 32'd0);

    // Every expected word must have been seen
    check("q0_left", 32'(q0.size()), 32'd0);
    check("q1_left", 32'(q1.size()), 32'd0);
    check("q2_left", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
